// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//
// Sends one frame per accepted request: a start bit (0), BITS_PER_DATA data bits LSB first, an
// optional parity bit, then 1-3 stop bits (1). Each bit lasts NUM_TICKS baud oversample ticks.
// Request, data, parity enable and stop-bit count are latched at acceptance and held for the
// whole frame.
//
// Build option:
//   UART_TX_ODD_PARITY_EN  defined: the parity bit is odd parity. Undefined: even parity.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   tick       1-clk baud oversample strobe; consecutive high cycles count as separate ticks
//   tx_start   send request, only honoured in idle (and not in the tx_done cycle)
//   d_in       byte to transmit
//   parity     1 = append a parity bit after the data bits
//   stop_bits  stop bit count, 0 is treated as 1
//   tx         serial line, registered, idles high
//   tx_done    1-clk pulse when the last stop tick has been counted
//   busy       high from the cycle after acceptance through the tx_done cycle
module uart_tx #(
  parameter int unsigned NUM_TICKS     = 16,
  parameter int unsigned BITS_PER_DATA = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     tx_start,
  input  logic [BITS_PER_DATA-1:0] d_in,
  input  logic                     parity,
  input  logic [1:0]               stop_bits,
  output logic                     tx,
  output logic                     tx_done,
  output logic                     busy
);

  // One counter serves every state; it must reach 3*NUM_TICKS-1 in the stop phase.
  localparam int unsigned SW = $clog2(3 * NUM_TICKS);
  localparam int unsigned NW = (BITS_PER_DATA > 1) ? $clog2(BITS_PER_DATA) : 1;

  localparam logic [SW-1:0] BitLast  = SW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] DataLast = NW'(BITS_PER_DATA - 1);

  localparam logic [4:0] StIdle   = 5'b00001;
  localparam logic [4:0] StStart  = 5'b00010;
  localparam logic [4:0] StData   = 5'b00100;
  localparam logic [4:0] StParity = 5'b01000;
  localparam logic [4:0] StStop   = 5'b10000;

  logic [4:0]               state_q, state_d;
  logic [SW-1:0]            s_q, s_d;
  logic [NW-1:0]            n_q, n_d;
  logic [BITS_PER_DATA-1:0] shift_q, shift_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic [1:0]               sb_q, sb_d;
  logic                     tx_q, tx_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic [SW-1:0]            stop_last;
  logic                     new_par_bit;

  // Parity is taken from the raw input at acceptance, before the shift register starts moving.
`ifdef UART_TX_ODD_PARITY_EN
  assign new_par_bit = ~(^d_in);
`else
  assign new_par_bit = ^d_in;
`endif

  // sb_q is already normalised to 1..3 at latch time.
  always_comb begin
    unique case (sb_q)
      2'd2:    stop_last = SW'(2 * NUM_TICKS - 1);
      2'd3:    stop_last = SW'(3 * NUM_TICKS - 1);
      default: stop_last = SW'(NUM_TICKS - 1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    sb_d      = sb_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A request overlapping the tx_done cycle is dropped, not deferred.
        if (tx_start && !done_q) begin
          shift_d   = d_in;
          par_en_d  = parity;
          par_bit_d = new_par_bit;
          sb_d      = (stop_bits == 2'd0) ? 2'd1 : stop_bits;
          s_d       = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            n_d     = '0;
            state_d = StData;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          if (s_q == BitLast) begin
            shift_d = shift_q >> 1;
            s_d     = '0;
            if (n_q == DataLast) begin
              state_d = par_en_q ? StParity : StStop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (s_q == BitLast) begin
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (s_q == stop_last) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        s_d     = '0;
        n_d     = '0;
      end
    endcase

    // busy stays up through the tx_done cycle, which is already spent in idle.
    busy_d = (state_d != StIdle) || done_d;

    // Line level is decoded from the next state so tx comes straight out of a flop.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      sb_q      <= 2'd1;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      sb_q      <= sb_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign busy    = busy_q;

endmodule
